jpeg_byte_stuffer: RTL and testbench



---
 rtl/jpeg_byte_stuffer.sv | 204 ++++++++++++++++++++
 tb/tb_jpeg_byte_stuffer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_byte_stuffer.sv
// ---------------------------------------------------------------------------
// jpeg_byte_stuffer
//
// Drains 32-bit entropy-coded words from the upstream output FIFO and
// serialises them MSB byte first onto a byte-wide valid/ready stream.
// Every 0xFF data byte is followed by a 0x00 stuff byte when
// ENABLE_STUFF=1. When end-of-image has been requested and the FIFO is
// empty, the two-byte EOI marker is appended without stuffing.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   fifo_empty   FIFO empty flag
//   read_req     FIFO read request (only ever asserted in IDLE)
//   read_data    FIFO read word, valid one cycle after read_req
//   rdata_valid  strobe qualifying read_data
//   eoi_req      end-of-image pulse; marker follows once data is drained
//   byte_out     output byte (0x00 whenever byte_valid is low)
//   byte_valid   byte_out is valid
//   byte_ready   downstream accepts byte_out when byte_valid && byte_ready
//   eoi_done     one-cycle pulse after the marker low byte is accepted
//   byte_count   total accepted bytes (data, stuff and marker), wraps
//
// State    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | waiting for data or a pending EOI; read_req = !fifo_empty
// S_WAIT   | read issued, capturing the word on rdata_valid
// S_SHIFT  | presenting data byte byte_idx of the held word
// S_STUFF  | presenting the 0x00 that follows a 0xFF data byte
// S_EOI_HI | presenting the marker high byte
// S_EOI_LO | presenting the marker low byte
// S_DONE   | eoi_done pulse, then back to idle
// ---------------------------------------------------------------------------
module jpeg_byte_stuffer #(
    parameter bit          ENABLE_STUFF = 1'b1,
    parameter logic [15:0] EOI_MARKER   = 16'hFFD9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_empty,
    output logic        read_req,
    input  logic [31:0] read_data,
    input  logic        rdata_valid,
    input  logic        eoi_req,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        eoi_done,
    output logic [31:0] byte_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SHIFT,
        S_STUFF,
        S_EOI_HI,
        S_EOI_LO,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic        eoi_pending_q, eoi_pending_d;
    logic        byte_valid_q, byte_valid_d;
    logic [7:0]  byte_out_q, byte_out_d;
    logic        eoi_done_q, eoi_done_d;
    logic [31:0] byte_count_q, byte_count_d;

    logic        accept;
    logic [1:0]  idx_inc;

    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    assign accept  = byte_valid_q && byte_ready;
    assign idx_inc = byte_idx_q + 2'd1;

    // Gated with rst so the request is low while reset is held even though
    // the FSM already sits in IDLE.
    assign read_req   = (state_q == S_IDLE) && !fifo_empty && !rst;
    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign eoi_done   = eoi_done_q;
    assign byte_count = byte_count_q;

    // Outputs are computed together with the next state so byte_out/byte_valid
    // come straight from flops and stay stable while the consumer stalls.
    always_comb begin
        state_d       = state_q;
        word_d        = word_q;
        byte_idx_d    = byte_idx_q;
        byte_valid_d  = byte_valid_q;
        byte_out_d    = byte_out_q;
        eoi_done_d    = 1'b0;
        eoi_pending_d = eoi_pending_q | eoi_req;
        byte_count_d  = accept ? byte_count_q + 32'd1 : byte_count_q;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_WAIT;
                end else if (eoi_pending_q) begin
                    state_d      = S_EOI_HI;
                    byte_valid_d = 1'b1;
                    byte_out_d   = EOI_MARKER[15:8];
                end
            end
            S_WAIT: begin
                if (rdata_valid) begin
                    state_d      = S_SHIFT;
                    word_d       = read_data;
                    byte_idx_d   = 2'd0;
                    byte_valid_d = 1'b1;
                    byte_out_d   = read_data[31:24];
                end
            end
            S_SHIFT: begin
                if (accept) begin
                    if (ENABLE_STUFF && (byte_out_q == 8'hFF)) begin
                        state_d    = S_STUFF;
                        byte_out_d = 8'h00;
                    end else if (byte_idx_q == 2'd3) begin
                        state_d      = S_IDLE;
                        byte_valid_d = 1'b0;
                        byte_out_d   = 8'h00;
                    end else begin
                        byte_idx_d = idx_inc;
                        byte_out_d = pick_byte(word_q, idx_inc);
                    end
                end
            end
            S_STUFF: begin
                if (accept) begin
                    if (byte_idx_q == 2'd3) begin
                        state_d      = S_IDLE;
                        byte_valid_d = 1'b0;
                        byte_out_d   = 8'h00;
                    end else begin
                        state_d    = S_SHIFT;
                        byte_idx_d = idx_inc;
                        byte_out_d = pick_byte(word_q, idx_inc);
                    end
                end
            end
            S_EOI_HI: begin
                if (accept) begin
                    state_d    = S_EOI_LO;
                    byte_out_d = EOI_MARKER[7:0];
                end
            end
            S_EOI_LO: begin
                if (accept) begin
                    state_d       = S_DONE;
                    byte_valid_d  = 1'b0;
                    byte_out_d    = 8'h00;
                    eoi_done_d    = 1'b1;
                    // A request landing on the final marker byte re-arms for another marker.
                    eoi_pending_d = eoi_req;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d      = S_IDLE;
                byte_valid_d = 1'b0;
                byte_out_d   = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            word_q        <= 32'd0;
            byte_idx_q    <= 2'd0;
            eoi_pending_q <= 1'b0;
            byte_valid_q  <= 1'b0;
            byte_out_q    <= 8'h00;
            eoi_done_q    <= 1'b0;
            byte_count_q  <= 32'd0;
        end else begin
            state_q       <= state_d;
            word_q        <= word_d;
            byte_idx_q    <= byte_idx_d;
            eoi_pending_q <= eoi_pending_d;
            byte_valid_q  <= byte_valid_d;
            byte_out_q    <= byte_out_d;
            eoi_done_q    <= eoi_done_d;
            byte_count_q  <= byte_count_d;
        end
    end

endmodule

// File: tb/tb_jpeg_byte_stuffer.sv
// ---------------------------------------------------------------------------
// tb_jpeg_byte_stuffer
//
// Two instances (stuffing on / off) share clock and reset; `sel` picks which
// one the FIFO model, byte sink and reference model are attached to. The
// reference model turns each popped word into its expected byte list and
// appends the marker once all data has gone out.
// ---------------------------------------------------------------------------
module tb_jpeg_byte_stuffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty_v = 1'b1;
    logic        rdata_valid_v = 1'b0;
    logic        eoi_req_v = 1'b0;
    logic        byte_ready = 1'b0;
    logic [31:0] read_data_v = 32'd0;
    bit          sel = 1'b0;

    logic        a_fe, a_rv, a_eoi, a_rr, a_bv, a_done;
    logic [7:0]  a_bo;
    logic [31:0] a_cnt;
    logic        b_fe, b_rv, b_eoi, b_rr, b_bv, b_done;
    logic [7:0]  b_bo;
    logic [31:0] b_cnt;

    logic        m_rr, m_bv, m_done;
    logic [7:0]  m_bo;
    logic [31:0] m_cnt;

    assign a_fe  = sel ? 1'b1 : fifo_empty_v;
    assign a_rv  = sel ? 1'b0 : rdata_valid_v;
    assign a_eoi = sel ? 1'b0 : eoi_req_v;
    assign b_fe  = sel ? fifo_empty_v : 1'b1;
    assign b_rv  = sel ? rdata_valid_v : 1'b0;
    assign b_eoi = sel ? eoi_req_v : 1'b0;

    assign m_rr   = sel ? b_rr : a_rr;
    assign m_bv   = sel ? b_bv : a_bv;
    assign m_bo   = sel ? b_bo : a_bo;
    assign m_done = sel ? b_done : a_done;
    assign m_cnt  = sel ? b_cnt : a_cnt;

    jpeg_byte_stuffer #(.ENABLE_STUFF(1'b1), .EOI_MARKER(16'hFFD9)) dut (
        .clk(clk), .rst(rst), .fifo_empty(a_fe), .read_req(a_rr),
        .read_data(read_data_v), .rdata_valid(a_rv), .eoi_req(a_eoi),
        .byte_out(a_bo), .byte_valid(a_bv), .byte_ready(byte_ready),
        .eoi_done(a_done), .byte_count(a_cnt)
    );

    jpeg_byte_stuffer #(.ENABLE_STUFF(1'b0), .EOI_MARKER(16'hFFD9)) dut_ns (
        .clk(clk), .rst(rst), .fifo_empty(b_fe), .read_req(b_rr),
        .read_data(read_data_v), .rdata_valid(b_rv), .eoi_req(b_eoi),
        .byte_out(b_bo), .byte_valid(b_bv), .byte_ready(byte_ready),
        .eoi_done(b_done), .byte_count(b_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] q[$];
    logic [7:0]  exp_q[$];
    int          acc_cyc[$];
    bit          model_pending = 0;
    bit          mk_idx = 0;
    bit          exp_done_next = 0;
    bit          prev_stall = 0;
    logic [7:0]  prev_byte = 8'h00;
    bit          rd_hit = 0;
    bit          eoi_next = 0;
    logic [31:0] cnt_model = 32'd0;
    int          cyc = 0;
    int          last_rd_cyc = 0;
    int          done_cnt = 0;
    int          spurious = 0;
    int          acc_total = 0;
    int          ready_mode = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w = 32'd0;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            w = {w[23:0], b};
        end
        return w;
    endfunction

    // JPEG rule: bytes MSB first, a 0x00 after every 0xFF when stuffing.
    task automatic expect_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            logic [7:0] b;
            b = 8'(w >> (8 * i));
            exp_q.push_back(b);
            if (!sel && b == 8'hFF) exp_q.push_back(8'h00);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        q.push_back(w);
        fifo_empty_v = 1'b0;
    endtask

    task automatic observe();
        bit accept;
        cyc++;
        chk("byte_count", m_cnt, cnt_model);
        chk("eoi_done", 32'(m_done), 32'(exp_done_next));
        if (m_done) done_cnt++;
        exp_done_next = 0;
        if (!m_bv) chk("idle_byte_zero", 32'(m_bo), 32'd0);
        if (prev_stall) begin
            chk("stall_valid", 32'(m_bv), 32'd1);
            chk("stall_byte", 32'(m_bo), 32'(prev_byte));
        end
        if (m_rr) begin
            chk("read_while_busy", 32'(exp_q.size() != 0 || rdata_valid_v), 32'd0);
            last_rd_cyc = cyc;
            rd_hit = 1;
        end
        accept = m_bv && byte_ready;
        if (accept) begin
            acc_cyc.push_back(cyc);
            acc_total++;
            if (exp_q.size() != 0) begin
                chk("data_byte", 32'(m_bo), 32'(exp_q.pop_front()));
            end else if (model_pending && q.size() == 0 && !rd_hit) begin
                chk("marker_byte", 32'(m_bo), mk_idx ? 32'hD9 : 32'hFF);
                if (mk_idx) begin
                    model_pending = 0;
                    exp_done_next = 1;
                end
                mk_idx = ~mk_idx;
            end else begin
                spurious++;
            end
            cnt_model = cnt_model + 32'd1;
        end
        if (sel ? b_eoi : a_eoi) model_pending = 1;
        prev_stall = m_bv && !byte_ready;
        prev_byte  = m_bo;
    endtask

    task automatic drive();
        if (rd_hit && q.size() != 0) begin
            read_data_v   = q.pop_front();
            rdata_valid_v = 1'b1;
            expect_word(read_data_v);
        end else begin
            read_data_v   = $urandom;
            rdata_valid_v = 1'b0;
        end
        rd_hit       = 0;
        fifo_empty_v = (q.size() == 0);
        case (ready_mode)
            0:       byte_ready = 1'b1;
            1:       byte_ready = 1'($urandom_range(0, 1));
            default: byte_ready = 1'b0;
        endcase
        eoi_req_v = eoi_next;
        eoi_next  = 0;
    endtask

    task automatic cycle();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic drain(input string tag, input int limit);
        int n = 0;
        while ((q.size() != 0 || exp_q.size() != 0 || model_pending || rdata_valid_v || m_bv)
               && n < limit) begin
            cycle();
            n++;
        end
        chk({tag, "_timeout"}, 32'(n >= limit), 32'd0);
        repeat (3) cycle();
    endtask

    task automatic clear_model();
        exp_q.delete();
        model_pending = 0;
        mk_idx = 0;
        exp_done_next = 0;
        prev_stall = 0;
        rd_hit = 0;
        cnt_model = 32'd0;
        rdata_valid_v = 1'b0;
        eoi_req_v = 1'b0;
        eoi_next = 0;
    endtask

    initial begin
        logic [31:0] base;
        int          dbase;
        int          n;
        int          a0;

        // Reset state while reset is held
        #2;
        chk("rst_valid", 32'(a_bv), 32'd0);
        chk("rst_byte", 32'(a_bo), 32'd0);
        chk("rst_read_req", 32'(a_rr), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_count", a_cnt, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        ready_mode = 0;
        repeat (2) cycle();

        // Plain word: read, 1-cycle wait, then 4 back-to-back bytes
        acc_cyc.delete();
        base = m_cnt;
        push_word(32'h12345678);
        drain("plain", 100);
        chk("plain_nbytes", 32'(acc_cyc.size()), 32'd4);
        chk("plain_first_lat", 32'(acc_cyc[0] - last_rd_cyc), 32'd2);
        chk("plain_last_lat", 32'(acc_cyc[3] - last_rd_cyc), 32'd5);
        chk("plain_count", m_cnt - base, 32'd4);

        // Stuffing
        base = m_cnt;
        push_word(32'hFF00FFAB);
        push_word(32'hFFFFFFFF);
        drain("stuff", 200);
        chk("stuff_count", m_cnt - base, 32'd14);

        // Backpressure; the second word must not be read before C3 goes out
        ready_mode = 1;
        base = m_cnt;
        push_word(32'hA1FFB2C3);
        push_word(32'h01020304);
        drain("bp", 400);
        chk("bp_count", m_cnt - base, 32'd9);

        // EOI after two queued words, a second request while pending is ignored
        ready_mode = 0;
        base = m_cnt;
        dbase = done_cnt;
        push_word(32'h00FF1122);
        push_word(32'h33445566);
        eoi_next = 1;
        repeat (3) cycle();
        eoi_next = 1;
        drain("eoi", 200);
        chk("eoi_done_pulses", 32'(done_cnt - dbase), 32'd1);
        chk("eoi_count", m_cnt - base, 32'd11);

        // Randomised words under random backpressure with periodic EOI
        ready_mode = 1;
        dbase = done_cnt;
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 8; i++) push_word(rand_word());
            eoi_next = 1;
            drain("rand", 2000);
        end
        chk("rand_done_pulses", 32'(done_cnt - dbase), 32'd4);

        // Asynchronous reset in the middle of a word (byte_idx 2)
        ready_mode = 0;
        push_word(32'h11223344);
        push_word(32'h55667788);
        a0 = acc_total;
        n = 0;
        while (acc_total - a0 < 2 && n < 50) begin
            cycle();
            n++;
        end
        chk("midword_timeout", 32'(n >= 50), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(a_bv), 32'd0);
        chk("async_rst_read_req", 32'(a_rr), 32'd0);
        chk("async_rst_count", a_cnt, 32'd0);
        chk("async_rst_byte", 32'(a_bo), 32'd0);
        clear_model();
        @(posedge clk);
        #3 rst = 1'b0;
        fifo_empty_v = (q.size() == 0);
        drain("post_rst", 200);
        chk("post_rst_count", m_cnt, 32'd4);

        // Counter wrap
        force dut.byte_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.byte_count_q;
        cnt_model = 32'hFFFF_FFFE;
        push_word(32'h0A0B0C0D);
        a0 = acc_total;
        n = 0;
        while (acc_total - a0 < 3 && n < 50) begin
            cycle();
            n++;
        end
        chk("wrap_value", m_cnt, 32'h0000_0001);
        drain("wrap", 100);

        // Stuffing disabled instance
        sel = 1'b1;
        clear_model();
        fifo_empty_v = 1'b1;
        repeat (2) cycle();
        base = m_cnt;
        push_word(32'hFF00FFAB);
        push_word(32'hFFFFFFFF);
        drain("nostuff", 200);
        chk("nostuff_count", m_cnt - base, 32'd8);
        ready_mode = 1;
        for (int i = 0; i < 8; i++) push_word(rand_word());
        eoi_next = 1;
        drain("nostuff_rand", 2000);

        chk("spurious_bytes", 32'(spurious), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
